// File: rtl/serv_dbg_rf_trace.sv
// serv_dbg_rf_trace: reassembles SERV RF RAM write beats into 32-bit register records and queues them for a debug consumer
//
// Ports:
//   clk, i_rst_n               core clock, asynchronous active-low reset
//   i_rf_waddr/w1wren/we/wdata RF write stream (index, writeback enable, beat strobe, beat byte)
//   o_trc_valid/reg/data       FIFO head record (register index, 32-bit value)
//   i_trc_ready                consumer pops the head record
//   o_ovf, o_drop_cnt          sticky drop flag and saturating drop count
//   i_ovf_clr                  clears o_ovf and o_drop_cnt
//
// Optional feature: define SERV_DBG_TRACE_CSR_EN to also trace CSR shadow indices 32..35.
module serv_dbg_rf_trace #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic [5:0]       i_rf_waddr,
    input  logic             i_rf_w1wren,
    input  logic             i_rf_we,
    input  logic [7:0]       i_rf_wdata,
    output logic             o_trc_valid,
    output logic [5:0]       o_trc_reg,
    output logic [31:0]      o_trc_data,
    input  logic             i_trc_ready,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_drop_cnt,
    input  logic             i_ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    logic [1:0]  bcnt;
    logic [1:0]  eb;
    logic [23:0] acc;
    logic [5:0]  idx;
    logic [AW:0] wp;
    logic [AW:0] rp;
    logic [37:0] mem [DEPTH];
    logic        idx_ok;
    logic        beat;
    logic        push;
    logic        pop;
    logic        empty;
    logic        full;
    logic        drop;
`ifdef SERV_DBG_TRACE_CSR_EN
    assign idx_ok = i_rf_waddr != 6'd0 && i_rf_waddr <= 6'd35;
`else
    assign idx_ok = i_rf_waddr != 6'd0 && i_rf_waddr <= 6'd31;
`endif
    assign beat  = i_rf_we && i_rf_w1wren && idx_ok;
    // a beat to a different index restarts the record at byte 0
    assign eb    = (bcnt != 2'd0 && i_rf_waddr != idx) ? 2'd0 : bcnt;
    assign push  = beat && eb == 2'd3;
    assign empty = wp == rp;
    assign full  = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
    assign pop   = !empty && i_trc_ready;
    assign drop  = push && full && !pop;
    // head fields are forced to zero while empty so reset leaves them at 0
    assign o_trc_valid = !empty;
    assign o_trc_reg   = empty ? 6'd0 : mem[rp[AW-1:0]][37:32];
    assign o_trc_data  = empty ? 32'd0 : mem[rp[AW-1:0]][31:0];
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bcnt       <= 2'd0;
            acc        <= 24'd0;
            idx        <= 6'd0;
            wp         <= '0;
            rp         <= '0;
            o_ovf      <= 1'b0;
            o_drop_cnt <= '0;
        end else begin
            if (!i_rf_w1wren) begin
                bcnt <= 2'd0;
            end else if (beat) begin
                bcnt       <= eb + 2'd1;
                idx        <= eb == 2'd0 ? i_rf_waddr : idx;
                acc[7:0]   <= eb == 2'd0 ? i_rf_wdata : acc[7:0];
                acc[15:8]  <= eb == 2'd1 ? i_rf_wdata : acc[15:8];
                acc[23:16] <= eb == 2'd2 ? i_rf_wdata : acc[23:16];
            end
            if (push && !drop)
                wp <= wp + (AW+1)'(1);
            if (pop)
                rp <= rp + (AW+1)'(1);
            if (drop) begin
                o_ovf      <= 1'b1;
                o_drop_cnt <= i_ovf_clr ? CNT_W'(1) : (&o_drop_cnt ? o_drop_cnt : o_drop_cnt + CNT_W'(1));
            end else if (i_ovf_clr) begin
                o_ovf      <= 1'b0;
                o_drop_cnt <= '0;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (push && !drop)
            mem[wp[AW-1:0]] <= {idx, i_rf_wdata, acc};
    end
endmodule

// File: tb/tb_serv_dbg_rf_trace.sv
// tb_serv_dbg_rf_trace: directed self-checking bench for serv_dbg_rf_trace (DEPTH=4, CNT_W=8)
module tb_serv_dbg_rf_trace;
    logic        clk;
    logic        i_rst_n;
    logic [5:0]  i_rf_waddr;
    logic        i_rf_w1wren;
    logic        i_rf_we;
    logic [7:0]  i_rf_wdata;
    logic        o_trc_valid;
    logic [5:0]  o_trc_reg;
    logic [31:0] o_trc_data;
    logic        i_trc_ready;
    logic        o_ovf;
    logic [7:0]  o_drop_cnt;
    logic        i_ovf_clr;
    int          cmp;
    int          bad;

    serv_dbg_rf_trace #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .i_rst_n(i_rst_n), .i_rf_waddr(i_rf_waddr), .i_rf_w1wren(i_rf_w1wren),
        .i_rf_we(i_rf_we), .i_rf_wdata(i_rf_wdata), .o_trc_valid(o_trc_valid),
        .o_trc_reg(o_trc_reg), .o_trc_data(o_trc_data), .i_trc_ready(i_trc_ready),
        .o_ovf(o_ovf), .o_drop_cnt(o_drop_cnt), .i_ovf_clr(i_ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // inputs change on the falling edge; outputs are sampled on the falling edge too
    task automatic bt(input logic we, input logic w1, input logic [5:0] a, input logic [7:0] d,
                      input logic rdy, input logic clr);
        @(negedge clk);
        i_rf_we = we; i_rf_w1wren = w1; i_rf_waddr = a; i_rf_wdata = d;
        i_trc_ready = rdy; i_ovf_clr = clr;
    endtask

    // four consecutive beats, LSB first; ready/clr only on the final beat; ends one cycle after beat 3
    task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic r3, input logic c3);
        bt(1, 1, a, d[7:0], 0, 0);
        bt(1, 1, a, d[15:8], 0, 0);
        bt(1, 1, a, d[23:16], 0, 0);
        bt(1, 1, a, d[31:24], r3, c3);
        bt(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset;
        i_rst_n = 0; i_rf_we = 0; i_rf_w1wren = 0; i_rf_waddr = 0; i_rf_wdata = 0;
        i_trc_ready = 0; i_ovf_clr = 0;
        repeat (2) @(negedge clk);
        cmp++; if (o_trc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got %b want 0", o_trc_valid); end
        cmp++; if (o_trc_reg !== 6'd0) begin bad++; $display("FAIL reset_reg got %0d want 0", o_trc_reg); end
        cmp++; if (o_trc_data !== 32'd0) begin bad++; $display("FAIL reset_data got %h want 0", o_trc_data); end
        cmp++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got %b want 0", o_ovf); end
        cmp++; if (o_drop_cnt !== 8'd0) begin bad++; $display("FAIL reset_cnt got %0d want 0", o_drop_cnt); end
        i_rst_n = 1;
    endtask

    task automatic test_single;
        wr(5, 32'h12345678, 0, 0);
        cmp++; if (o_trc_valid !== 1'b1) begin bad++; $display("FAIL single_valid got %b want 1", o_trc_valid); end
        cmp++; if (o_trc_reg !== 6'd5) begin bad++; $display("FAIL single_reg got %0d want 5", o_trc_reg); end
        cmp++; if (o_trc_data !== 32'h12345678) begin bad++; $display("FAIL single_data got %h want 12345678", o_trc_data); end
        i_trc_ready = 1;
        @(negedge clk);
        i_trc_ready = 0;
        cmp++; if (o_trc_valid !== 1'b0) begin bad++; $display("FAIL single_popped got %b want 0", o_trc_valid); end
    endtask

    task automatic test_x0_abort;
        wr(0, 32'hDEADBEEF, 0, 0);
        cmp++; if (o_trc_valid !== 1'b0) begin bad++; $display("FAIL x0_valid got %b want 0", o_trc_valid); end
        bt(1, 1, 7, 8'hEE, 0, 0);
        bt(1, 1, 7, 8'hEF, 0, 0);
        bt(0, 0, 7, 8'h00, 0, 0);
        wr(7, 32'h04030201, 0, 0);
        cmp++; if (o_trc_valid !== 1'b1) begin bad++; $display("FAIL abort_valid got %b want 1", o_trc_valid); end
        cmp++; if (o_trc_reg !== 6'd7) begin bad++; $display("FAIL abort_reg got %0d want 7", o_trc_reg); end
        cmp++; if (o_trc_data !== 32'h04030201) begin bad++; $display("FAIL abort_data got %h want 04030201", o_trc_data); end
        i_trc_ready = 1;
        @(negedge clk);
        i_trc_ready = 0;
        cmp++; if (o_trc_valid !== 1'b0) begin bad++; $display("FAIL abort_one_record got %b want 0", o_trc_valid); end
        cmp++; if (o_drop_cnt !== 8'd0) begin bad++; $display("FAIL abort_cnt got %0d want 0", o_drop_cnt); end
    endtask

    task automatic test_gap_switch;
        bt(1, 1, 12, 8'h11, 0, 0);
        bt(0, 1, 12, 8'h00, 0, 0);
        bt(1, 1, 13, 8'h22, 0, 0);
        bt(0, 1, 13, 8'h00, 0, 0);
        bt(1, 1, 13, 8'h33, 0, 0);
        bt(1, 1, 13, 8'h44, 0, 0);
        bt(1, 1, 13, 8'h55, 0, 0);
        bt(0, 0, 0, 0, 0, 0);
        cmp++; if (o_trc_reg !== 6'd13) begin bad++; $display("FAIL switch_reg got %0d want 13", o_trc_reg); end
        cmp++; if (o_trc_data !== 32'h55443322) begin bad++; $display("FAIL switch_data got %h want 55443322", o_trc_data); end
        i_trc_ready = 1;
        @(negedge clk);
        i_trc_ready = 0;
        cmp++; if (o_trc_valid !== 1'b0) begin bad++; $display("FAIL switch_one_record got %b want 0", o_trc_valid); end
    endtask

    task automatic test_overflow;
        for (int i = 1; i <= 6; i++) wr(6'(i), 32'hCAFE0000 | i, 0, 0);
        cmp++; if (o_ovf !== 1'b1) begin bad++; $display("FAIL ovf_flag got %b want 1", o_ovf); end
        cmp++; if (o_drop_cnt !== 8'd2) begin bad++; $display("FAIL ovf_cnt got %0d want 2", o_drop_cnt); end
        cmp++; if (o_trc_reg !== 6'd1) begin bad++; $display("FAIL ovf_head_reg got %0d want 1", o_trc_reg); end
        cmp++; if (o_trc_data !== 32'hCAFE0001) begin bad++; $display("FAIL ovf_head_data got %h want cafe0001", o_trc_data); end
        wr(7, 32'hCAFE0007, 0, 1);
        cmp++; if (o_ovf !== 1'b1) begin bad++; $display("FAIL clr_drop_flag got %b want 1", o_ovf); end
        cmp++; if (o_drop_cnt !== 8'd1) begin bad++; $display("FAIL clr_drop_cnt got %0d want 1", o_drop_cnt); end
        bt(0, 0, 0, 0, 0, 1);
        bt(0, 0, 0, 0, 0, 0);
        cmp++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL clr_flag got %b want 0", o_ovf); end
        cmp++; if (o_drop_cnt !== 8'd0) begin bad++; $display("FAIL clr_cnt got %0d want 0", o_drop_cnt); end
    endtask

    task automatic test_full_pop;
        logic [5:0]  er [4] = '{6'd2, 6'd3, 6'd4, 6'd9};
        logic [31:0] ed [4] = '{32'hCAFE0002, 32'hCAFE0003, 32'hCAFE0004, 32'h99887766};
        wr(9, 32'h99887766, 1, 0);
        cmp++; if (o_ovf !== 1'b0) begin bad++; $display("FAIL fullpop_flag got %b want 0", o_ovf); end
        cmp++; if (o_drop_cnt !== 8'd0) begin bad++; $display("FAIL fullpop_cnt got %0d want 0", o_drop_cnt); end
        for (int i = 0; i < 4; i++) begin
            cmp++; if (o_trc_valid !== 1'b1) begin bad++; $display("FAIL drain_valid[%0d] got %b want 1", i, o_trc_valid); end
            cmp++; if (o_trc_reg !== er[i]) begin bad++; $display("FAIL drain_reg[%0d] got %0d want %0d", i, o_trc_reg, er[i]); end
            cmp++; if (o_trc_data !== ed[i]) begin bad++; $display("FAIL drain_data[%0d] got %h want %h", i, o_trc_data, ed[i]); end
            i_trc_ready = 1;
            @(negedge clk);
            i_trc_ready = 0;
        end
        cmp++; if (o_trc_valid !== 1'b0) begin bad++; $display("FAIL drain_empty got %b want 0", o_trc_valid); end
    endtask

    task automatic test_csr;
        wr(33, 32'hDDCCBBAA, 0, 0);
`ifdef SERV_DBG_TRACE_CSR_EN
        cmp++; if (o_trc_valid !== 1'b1) begin bad++; $display("FAIL csr_valid got %b want 1", o_trc_valid); end
        cmp++; if (o_trc_reg !== 6'd33) begin bad++; $display("FAIL csr_reg got %0d want 33", o_trc_reg); end
        cmp++; if (o_trc_data !== 32'hDDCCBBAA) begin bad++; $display("FAIL csr_data got %h want ddccbbaa", o_trc_data); end
        i_trc_ready = 1;
        @(negedge clk);
        i_trc_ready = 0;
`else
        cmp++; if (o_trc_valid !== 1'b0) begin bad++; $display("FAIL csr_ignored got %b want 0", o_trc_valid); end
        cmp++; if (o_drop_cnt !== 8'd0) begin bad++; $display("FAIL csr_cnt got %0d want 0", o_drop_cnt); end
`endif
    endtask

    task automatic test_reset_mid;
        wr(10, 32'h0A0A0A0A, 0, 0);
        wr(11, 32'h0B0B0B0B, 0, 0);
        cmp++; if (o_trc_reg !== 6'd10) begin bad++; $display("FAIL pre_rst_reg got %0d want 10", o_trc_reg); end
        bt(1, 1, 8, 8'h81, 0, 0);
        bt(1, 1, 8, 8'h82, 0, 0);
        bt(1, 1, 8, 8'h83, 0, 0);
        @(negedge clk);
        i_rf_we = 0; i_rf_w1wren = 0;
        i_rst_n = 0;
        #1;
        cmp++; if (o_trc_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got %b want 0", o_trc_valid); end
        cmp++; if (o_trc_reg !== 6'd0) begin bad++; $display("FAIL rst_mid_reg got %0d want 0", o_trc_reg); end
        cmp++; if (o_trc_data !== 32'd0) begin bad++; $display("FAIL rst_mid_data got %h want 0", o_trc_data); end
        @(negedge clk);
        i_rst_n = 1;
        wr(8, 32'h44332211, 0, 0);
        cmp++; if (o_trc_valid !== 1'b1) begin bad++; $display("FAIL post_rst_valid got %b want 1", o_trc_valid); end
        cmp++; if (o_trc_reg !== 6'd8) begin bad++; $display("FAIL post_rst_reg got %0d want 8", o_trc_reg); end
        cmp++; if (o_trc_data !== 32'h44332211) begin bad++; $display("FAIL post_rst_data got %h want 44332211", o_trc_data); end
        i_trc_ready = 1;
        @(negedge clk);
        i_trc_ready = 0;
        cmp++; if (o_trc_valid !== 1'b0) begin bad++; $display("FAIL post_rst_one_record got %b want 0", o_trc_valid); end
    endtask

    initial begin
        cmp = 0;
        bad = 0;
        test_reset;
        test_single;
        test_x0_abort;
        test_gap_switch;
        test_overflow;
        test_full_pop;
        test_csr;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
        $finish;
    end
endmodule

// File: doc/serv_dbg_rf_trace.md
# serv_dbg_rf_trace

Debug-side consumer of the register-file RAM write stream exported by the SERV RF top level. It reassembles the 8-bit RAM write beats of each destination-register write into one 32-bit record tagged with the register index, then queues records in a small FIFO for the debug module to drain with a valid/ready handshake. The block is passive: it never stalls the core. Records that cannot be queued are dropped and counted.

## Interface
Parameters:
- DEPTH, 4: FIFO depth in records; power of two, at least 2.
- CNT_W, 8: width of the saturating drop counter.

Ports:
- clk  in  1  core clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_rf_waddr  in  6  RF write register index (write port 1 register)
- i_rf_w1wren  in  1  write-port-1 enable; high for the whole rd writeback
- i_rf_we  in  1  RAM write strobe; one pulse per 8-bit beat
- i_rf_wdata  in  8  RAM write beat data
- o_trc_valid  out  1  FIFO head record valid
- o_trc_reg  out  6  register index of head record
- o_trc_data  out  32  32-bit value of head record
- i_trc_ready  in  1  consumer accepts head record
- o_ovf  out  1  sticky: at least one record dropped
- o_drop_cnt  out  CNT_W  number of dropped records, saturating
- i_ovf_clr  in  1  clears o_ovf and o_drop_cnt

## Operation
- A beat is a cycle with i_rf_we=1, i_rf_w1wren=1 and an accepted index:
  - indices 1..31 are always accepted;
  - index 0 is never accepted;
  - indices 32..35 (CSR shadow) follow Configuration.
- Beat counter bcnt[1:0] and 24-bit accumulator acc. Beat n places i_rf_wdata in byte n (first beat = bits 7:0, LSB first).
- The index is latched on beat 0. If a later beat arrives with a different i_rf_waddr, discard the partial record; the beat becomes beat 0 of the new index.
- If i_rf_w1wren falls while bcnt≠0, discard the partial record and set bcnt=0. No record and no drop count.
- Beat 3 completes the record {index, wdata, acc} and pushes it to the FIFO.
- Push succeeds if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
- Otherwise the record is discarded, o_ovf is set, and o_drop_cnt increments, saturating at all ones.
- Pop occurs when o_trc_valid && i_trc_ready. Order is FIFO.
- Outputs show the head entry while o_trc_valid=1; o_trc_reg and o_trc_data are don't-care while o_trc_valid=0.
- i_ovf_clr: o_ovf and o_drop_cnt are 0 next cycle. If a drop occurs in the same cycle, the drop wins: o_ovf=1, o_drop_cnt=1.
- FIFO storage: DEPTH entries of 38 bits, read/write pointers of log2(DEPTH)+1 bits. Full when the MSBs differ and the low bits are equal. Pointers wrap modulo 2·DEPTH.

## Timing
- Reset, asynchronous and active-low. All of the following are 0: o_trc_valid, o_trc_reg, o_trc_data, o_ovf, o_drop_cnt, bcnt, acc, and the FIFO pointers. Deassertion is synchronous to clk, applied externally.
- Latency: a record completed by beat 3 in cycle t gives o_trc_valid=1 in cycle t+1 when the FIFO was empty.
- Pop in cycle t:
  - the next entry is visible at t+1;
  - o_trc_valid falls at t+1 if the popped entry was the last one.
- Push and pop in the same cycle when empty: the push is not visible until t+1, so there is no fall-through bypass.
- Beats need not be consecutive. Gaps with i_rf_we=0 and i_rf_w1wren=1 hold the state.
- o_trc_valid, once high, stays high until popped. The head data is stable while not popped.

## Configuration
- SERV_DBG_TRACE_CSR_EN defined: indices 32..35 are accepted and traced like GPRs.
- Not defined: beats to indices 32..35 are ignored. No record, no drop count, and bcnt is unaffected.

## Test plan
- Single write: x5, beats 0x78,0x56,0x34,0x12 on consecutive cycles, i_trc_ready=1 → one cycle after beat 3, o_trc_valid=1, o_trc_reg=5, o_trc_data=0x12345678; popped that cycle; o_trc_valid=0 the cycle after.
- x0 and abort:
  - four beats to x0 → no record;
  - two beats to x7, then i_rf_w1wren low, then four beats 0x01..0x04 to x7 → exactly one record: reg 7, data 0x04030201.
- Overflow with DEPTH=4, i_trc_ready=0, six complete writes to x1..x6 → FIFO holds x1..x4 in order; o_ovf=1; o_drop_cnt=2. Then i_ovf_clr pulse → both 0.
- Full plus simultaneous pop: FIFO full, pop on the same cycle that x9 completes → no drop; drain order x2,x3,x4,x9.
- Configuration: beats 0xAA,0xBB,0xCC,0xDD to index 33 → with SERV_DBG_TRACE_CSR_EN, record reg 33, data 0xDDCCBBAA; without it, no record and o_drop_cnt=0.
- Reset mid-operation: i_rst_n low after beat 2 of x8 with 2 records queued → outputs 0 immediately. After release, four beats to x8 produce exactly one record with the new data.
